// File: rtl/lcd_bus_arbiter.sv
// Arbitrates a command-byte requester and an RGB565 pixel requester onto an
// 8-bit 8080-style LCD write bus with programmable wr low/high phase lengths.
module lcd_bus_arbiter #(
  parameter int unsigned WR_LOW  = 2,
  parameter int unsigned WR_HIGH = 2
) (
  input  logic        hwclk,
  input  logic        nrst,
  input  logic        cmd_req,
  input  logic        cmd_dcx,
  input  logic [7:0]  cmd_byte,
  output logic        cmd_ack,
  input  logic        pix_req,
  input  logic [15:0] pix_data,
  output logic        pix_ack,
  output logic        busy,
  output logic        dcx,
  output logic        wr,
  output logic [7:0]  D
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  localparam logic [3:0] LO_LOAD = 4'(WR_LOW - 1);
  localparam logic [3:0] HI_LOAD = 4'(WR_HIGH - 1);

  state_t     r_state, w_state;
  logic [3:0] r_cnt, w_cnt;
  logic       r_second, w_second;     // pixel low byte still to be written
  logic [7:0] r_lo_byte, w_lo_byte;
  logic       r_last_cmd, w_last_cmd; // previous grant went to the command side
  logic       r_cmd_ack, w_cmd_ack;
  logic       r_pix_ack, w_pix_ack;
  logic       r_busy, w_busy;
  logic       r_dcx, w_dcx;
  logic       r_wr, w_wr;
  logic [7:0] r_d, w_d;
  logic       w_pix_win;

  // Pixel wins when it is alone, or when the command side had the last turn.
  assign w_pix_win = pix_req & (~cmd_req | r_last_cmd);

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no
    // path through this block leaves one unassigned, which would infer a latch.
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_second   = r_second;
    w_lo_byte  = r_lo_byte;
    w_last_cmd = r_last_cmd;
    w_cmd_ack  = 1'b0;
    w_pix_ack  = 1'b0;
    w_dcx      = r_dcx;
    w_wr       = r_wr;
    w_d        = r_d;

    case (r_state)
      IDLE: begin
        if (cmd_req | pix_req) begin
          w_state = WR_LO;
          w_wr    = 1'b0;
          w_cnt   = LO_LOAD;
          if (w_pix_win) begin
            w_pix_ack  = 1'b1;
            w_dcx      = 1'b1;
            w_d        = pix_data[15:8];
            w_lo_byte  = pix_data[7:0];
            w_second   = 1'b1;
            w_last_cmd = 1'b0;
          end else begin
            w_cmd_ack  = 1'b1;
            w_dcx      = cmd_dcx;
            w_d        = cmd_byte;
            w_second   = 1'b0;
            w_last_cmd = 1'b1;
          end
        end
      end

      WR_LO: begin
        if (r_cnt != 4'd0) begin
          w_cnt = r_cnt - 4'd1;
        end else begin
          w_state = WR_HI;
          w_wr    = 1'b1;
          w_cnt   = HI_LOAD;
        end
      end

      WR_HI: begin
        if (r_cnt != 4'd0) begin
          w_cnt = r_cnt - 4'd1;
        end else if (r_second) begin
          // Pixel low byte follows immediately, without an idle cycle.
          w_state  = WR_LO;
          w_wr     = 1'b0;
          w_cnt    = LO_LOAD;
          w_d      = r_lo_byte;
          w_second = 1'b0;
        end else begin
          w_state = IDLE;
        end
      end

      default: begin
        w_state = IDLE;
        w_wr    = 1'b1;
      end
    endcase

    w_busy = (w_state != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_second   <= 1'b0;
      r_lo_byte  <= 8'h00;
      r_last_cmd <= 1'b0;
      r_cmd_ack  <= 1'b0;
      r_pix_ack  <= 1'b0;
      r_busy     <= 1'b0;
      r_dcx      <= 1'b1;
      r_wr       <= 1'b1;
      r_d        <= 8'h00;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_second   <= w_second;
      r_lo_byte  <= w_lo_byte;
      r_last_cmd <= w_last_cmd;
      r_cmd_ack  <= w_cmd_ack;
      r_pix_ack  <= w_pix_ack;
      r_busy     <= w_busy;
      r_dcx      <= w_dcx;
      r_wr       <= w_wr;
      r_d        <= w_d;
    end
  end

  assign cmd_ack = r_cmd_ack;
  assign pix_ack = r_pix_ack;
  assign busy    = r_busy;
  assign dcx     = r_dcx;
  assign wr      = r_wr;
  assign D       = r_d;

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter WR_LOW, default 2, wr low-phase length in hwclk cycles, legal 1..15.
REQ-002 SHALL have parameter WR_HIGH, default 2, wr high-phase length in hwclk cycles, legal 1..15.
REQ-003 SHALL have port hwclk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_req  input  1  command requester wants one byte written.
REQ-006 SHALL have port cmd_dcx  input  1  D/C level for the command byte (0=command, 1=parameter).
REQ-007 SHALL have port cmd_byte  input  8  command/parameter byte.
REQ-008 SHALL have port cmd_ack  output  1  one-cycle pulse: cmd_dcx/cmd_byte captured.
REQ-009 SHALL have port pix_req  input  1  pixel requester wants one RGB565 pixel written.
REQ-010 SHALL have port pix_data  input  16  RGB565 pixel.
REQ-011 SHALL have port pix_ack  output  1  one-cycle pulse: pix_data captured.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port dcx  output  1  LCD data/command select.
REQ-014 SHALL have port wr  output  1  LCD write strobe, active-low, panel latches on rising edge.
REQ-015 SHALL have port D  output  8  LCD parallel data bus.

Function
REQ-016 SHALL implement FSM states IDLE, WR_LO, WR_HI; all outputs registered.
REQ-017 In IDLE with any request high, SHALL grant at the next edge: pulse the winner's ack for exactly one cycle, load D/dcx, enter WR_LO (wr=0).
REQ-018 Arbitration: cmd_req wins over pix_req, except when the previous grant was cmd and pix_req is high, then pix wins (alternating; no starvation either way).
REQ-019 Pixel grant SHALL drive dcx=1, D=pix_data[15:8] first, then pix_data[7:0]; both bytes captured at grant; transaction atomic, no cmd interleaved.
REQ-020 Command grant SHALL drive dcx=cmd_dcx, D=cmd_byte, one byte.
REQ-021 wr SHALL stay 0 for exactly WR_LOW cycles, then 1 for exactly WR_HIGH cycles (WR_HI); D and dcx stable across both phases.
REQ-022 After WR_HI of a pixel's first byte SHALL go directly to WR_LO with the low byte (no IDLE cycle).
REQ-023 After WR_HI of the final byte SHALL return to IDLE for at least one cycle; byte period for cmd = WR_LOW+WR_HIGH+1 cycles, pixel = 2*(WR_LOW+WR_HIGH)+1.
REQ-024 Phase counter SHALL be 4 bits, count down from parameter-1 to 0, no wrap beyond phase end.
REQ-025 Requests SHALL be level, held until ack; requests and input data changes while busy SHALL be ignored.
REQ-026 Simultaneous cmd_req and pix_req SHALL yield exactly one ack per grant, never both.
REQ-027 D and dcx SHALL hold their last values in IDLE.

Reset
REQ-028 nrst low SHALL immediately force state IDLE, wr=1, dcx=1, D=8'h00, cmd_ack=0, pix_ack=0, busy=0, arbitration history = "last grant pix".
REQ-029 Reset mid-write SHALL abort the byte (wr high immediately), no ack reissued; operation resumes on the first edge after nrst rises.

Verification (WR_LOW=2, WR_HIGH=2)
REQ-030 Reset: nrst=0 mid-WR_LO -> wr=1, D=8'h00, dcx=1, busy=0 without waiting for a clock edge.
REQ-031 Single cmd: cmd_req=1, cmd_dcx=0, cmd_byte=8'h2C -> cmd_ack one cycle, wr low 2 cycles, high 2 cycles, D=8'h2C, dcx=0, busy=0 on cycle 5.
REQ-032 Single pixel 16'hF800 -> pix_ack once, D=8'hF8 then 8'h00, dcx=1, two wr rising edges 4 cycles apart, 9 cycles total.
REQ-033 Simultaneous requests held high from reset -> grant order cmd, pix, cmd, pix; ack counts equal; no overlap.
REQ-034 Data change during busy: cmd_byte altered mid-WR_LO -> D unchanged until the next grant.
REQ-035 Back-to-back cmds with pix_req=0 -> one IDLE cycle between bytes, exactly 5-cycle period.
